// File: rtl/fir_tap_feeder.sv
// Sample-side feeder for the 64-tap FIR MAC: keeps the last TAPS samples in a
// circular RAM and replays the window newest-first, one tap per clock.
module fir_tap_feeder #(
   parameter int TAPS      = 64,
   parameter int ADDR_BITS = 6,
   parameter int WIDTH     = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [WIDTH-1:0]     sample_in,
   input  logic                 sample_valid,
   output logic                 ready,
   output logic [WIDTH-1:0]     x,
   output logic                 x_valid,
   output logic [ADDR_BITS-1:0] tap,
   output logic                 frame_start,
   output logic                 frame_end,
   output logic                 overrun
);

   localparam logic [1:0] CLEAR = 2'd0;
   localparam logic [1:0] IDLE  = 2'd1;
   localparam logic [1:0] RUN   = 2'd2;

   localparam logic [ADDR_BITS-1:0] LAST = ADDR_BITS'(TAPS - 1);

   logic [1:0]              state;
   logic [ADDR_BITS-1:0]    wp;
   logic [ADDR_BITS-1:0]    base;
   logic [ADDR_BITS-1:0]    k;
   logic [ADDR_BITS-1:0]    clr;
   logic                    pending_valid;
   logic signed [WIDTH-1:0] pending;

   logic signed [WIDTH-1:0] mem [TAPS];

   logic                    mem_we;
   logic [ADDR_BITS-1:0]    mem_waddr;
   logic signed [WIDTH-1:0] mem_wdata;
   logic [ADDR_BITS-1:0]    rd_addr;
   logic                    start;
   logic signed [WIDTH-1:0] start_sample;
   logic                    pend_load;

   // A held sample always wins over a fresh strobe so frames stay in arrival order.
   always_comb begin
      mem_we       = 1'b0;
      mem_waddr    = wp;
      mem_wdata    = pending;
      start        = 1'b0;
      start_sample = pending;
      case (state)
         CLEAR: begin
            mem_we    = 1'b1;
            mem_waddr = clr;
            mem_wdata = '0;
         end
         IDLE: begin
            if (pending_valid) begin
               start        = 1'b1;
               start_sample = pending;
            end else if (sample_valid) begin
               start        = 1'b1;
               start_sample = $signed(sample_in);
            end
            if (start) begin
               mem_we    = 1'b1;
               mem_waddr = wp;
               mem_wdata = start_sample;
            end
         end
         default: ;
      endcase
   end

   assign rd_addr   = base - k;
   assign ready     = (state != CLEAR) && !pending_valid;
   assign pend_load = sample_valid &&
                      (((state == IDLE) && pending_valid) ||
                       ((state == RUN) && !pending_valid));

   always_ff @(posedge clk) begin
      if (mem_we && !reset)
         mem[mem_waddr] <= mem_wdata;
   end

   always_ff @(posedge clk) begin
      if (pend_load)
         pending <= $signed(sample_in);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= CLEAR;
         clr           <= '0;
         wp            <= '0;
         base          <= '0;
         k             <= '0;
         pending_valid <= 1'b0;
         overrun       <= 1'b0;
      end else begin
         case (state)
            CLEAR: begin
               clr <= clr + 1'b1;
               if (clr == LAST)
                  state <= IDLE;
               if (sample_valid)
                  overrun <= 1'b1;
            end
            IDLE: begin
               if (start) begin
                  base  <= wp;
                  wp    <= wp + 1'b1;
                  k     <= '0;
                  state <= RUN;
               end
               // Consuming the held sample frees the slot for a same-cycle strobe.
               if (pending_valid && !sample_valid)
                  pending_valid <= 1'b0;
            end
            RUN: begin
               k <= k + 1'b1;
               if (k == LAST)
                  state <= IDLE;
               if (sample_valid) begin
                  if (!pending_valid)
                     pending_valid <= 1'b1;
                  else
                     overrun <= 1'b1;
               end
            end
            default: state <= CLEAR;
         endcase
      end
   end

   // Registered read stage: x/tap follow the read issue by one clock.
   always_ff @(posedge clk) begin
      if (reset) begin
         x           <= '0;
         x_valid     <= 1'b0;
         tap         <= '0;
         frame_start <= 1'b0;
         frame_end   <= 1'b0;
      end else begin
         x_valid     <= (state == RUN);
         frame_start <= (state == RUN) && (k == '0);
         frame_end   <= (state == RUN) && (k == LAST);
         if (state == RUN) begin
            x   <= mem[rd_addr];
            tap <= k;
         end
      end
   end

endmodule

// File: tb/tb_fir_tap_feeder.sv
// Directed bench for fir_tap_feeder: a scoreboard queue is filled as strobes
// are issued and a negedge monitor pops one entry per x_valid cycle.
module tb_fir_tap_feeder;
   localparam int TAPS = 64;
   localparam int AB   = 6;
   localparam int W    = 16;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic [W-1:0]  sample_in = '0;
   logic          sample_valid = 1'b0;
   logic          ready;
   logic [W-1:0]  x;
   logic          x_valid;
   logic [AB-1:0] tap;
   logic          frame_start;
   logic          frame_end;
   logic          overrun;

   always #5 clk = ~clk;

   fir_tap_feeder #(.TAPS(TAPS), .ADDR_BITS(AB), .WIDTH(W)) dut (
      .clk(clk), .reset(reset), .sample_in(sample_in), .sample_valid(sample_valid),
      .ready(ready), .x(x), .x_valid(x_valid), .tap(tap),
      .frame_start(frame_start), .frame_end(frame_end), .overrun(overrun)
   );

   int checks = 0;
   int failures = 0;
   logic [23:0] sb[$];
   logic [W-1:0] hist [TAPS];

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", name, act, exp);
      end
   endtask

   function automatic void clear_model();
      for (int i = 0; i < TAPS; i++) hist[i] = '0;
   endfunction

   // Expected frame: newest sample first, flags on the first and last tap.
   function automatic void push_frame(logic [W-1:0] v);
      for (int i = TAPS - 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = v;
      for (int k = 0; k < TAPS; k++)
         sb.push_back({hist[k], AB'(k), (k == 0), (k == TAPS - 1)});
   endfunction

   always @(negedge clk) begin
      if (x_valid) begin
         if (sb.size() == 0) begin
            check("unexpected_x_valid", 32'(x_valid), 32'd0);
         end else begin
            logic [23:0] e;
            e = sb.pop_front();
            check("frame_entry", {8'd0, x, tap, frame_start, frame_end}, {8'd0, e});
         end
      end
   end

   task automatic strobe(logic [W-1:0] v);
      sample_in    = v;
      sample_valid = 1'b1;
      @(negedge clk);
      sample_valid = 1'b0;
   endtask

   task automatic wait_tap(int t, string name);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(x_valid && tap == t[AB-1:0]) && n < 400);
      if (n >= 400) check(name, 32'd0, 32'd1);
   endtask

   task automatic wait_end(string name);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(x_valid && frame_end) && n < 400);
      if (n >= 400) check(name, 32'd0, 32'd1);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic clear_sweep(string name);
      int n = 0;
      while (!ready && n < 200) begin
         n++;
         @(negedge clk);
      end
      check(name, 32'(n), 32'd64);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      clear_model();
      @(negedge clk);

      // 1: reset state, clear sweep length, single impulse frame
      do_reset();
      check("rst_x_valid", 32'(x_valid), 32'd0);
      check("rst_overrun", 32'(overrun), 32'd0);
      check("rst_tap", 32'(tap), 32'd0);
      check("rst_x", 32'(x), 32'd0);
      check("rst_flags", {30'd0, frame_start, frame_end}, 32'd0);
      clear_sweep("t1_clear_len");
      strobe(16'h1234);
      push_frame(16'h1234);
      wait_end("t1_end_timeout");
      @(negedge clk);
      check("t1_after_frame", 32'(x_valid), 32'd0);

      // 2: ramp 1..70, write pointer wraps past 64
      for (int v = 1; v < 70; v++) begin
         strobe(W'(v));
         push_frame(W'(v));
         repeat (99) @(negedge clk);
      end
      strobe(16'd70);
      push_frame(16'd70);
      wait_tap(0, "t2_tap0_timeout");
      check("t2_tap0", 32'(x), 32'd70);
      wait_tap(63, "t2_tap63_timeout");
      check("t2_tap63", 32'(x), 32'd7);
      repeat (5) @(negedge clk);

      // 3: second strobe mid-frame is pended, one bubble between frames
      strobe(16'h0100);
      push_frame(16'h0100);
      wait_tap(10, "t3_tap10_timeout");
      strobe(16'h0200);
      push_frame(16'h0200);
      check("t3_ready_pending", 32'(ready), 32'd0);
      wait_end("t3_endA_timeout");
      @(negedge clk);
      check("t3_bubble", 32'(x_valid), 32'd0);
      @(negedge clk);
      check("t3_B_tap0", {15'd0, x_valid, x}, {15'd0, 1'b1, 16'h0200});
      @(negedge clk);
      check("t3_B_tap1", {15'd0, x_valid, x}, {15'd0, 1'b1, 16'h0100});
      wait_end("t3_endB_timeout");

      // 4: three strobes in one frame: 2nd pended, 3rd dropped
      @(negedge clk);
      strobe(16'h0A01);
      push_frame(16'h0A01);
      wait_tap(5, "t4_tap5_timeout");
      strobe(16'h0A02);
      push_frame(16'h0A02);
      wait_tap(20, "t4_tap20_timeout");
      check("t4_ovr_before", 32'(overrun), 32'd0);
      strobe(16'h0A03);
      check("t4_ovr_set", 32'(overrun), 32'd1);
      wait_end("t4_endC_timeout");
      wait_end("t4_endD_timeout");
      check("t4_ovr_sticky", 32'(overrun), 32'd1);

      // 5: reset mid-frame aborts output, then a fresh clear sweep
      @(negedge clk);
      strobe(16'h0ABC);
      push_frame(16'h0ABC);
      wait_tap(30, "t5_tap30_timeout");
      do_reset();
      sb.delete();
      clear_model();
      check("t5_x_valid_off", 32'(x_valid), 32'd0);
      check("t5_ovr_cleared", 32'(overrun), 32'd0);
      clear_sweep("t5_clear_len");
      strobe(16'h7FFF);
      push_frame(16'h7FFF);
      wait_end("t5_end_timeout");

      // 6: strobe during clear is dropped and never reaches memory
      @(negedge clk);
      do_reset();
      sb.delete();
      clear_model();
      repeat (10) @(negedge clk);
      strobe(16'h5555);
      check("t6_ovr", 32'(overrun), 32'd1);
      n = 0;
      while (!ready && n < 200) begin
         n++;
         @(negedge clk);
      end
      check("t6_ready_after_clear", 32'(ready), 32'd1);
      n = 0;
      repeat (100) begin
         @(negedge clk);
         if (x_valid) n++;
      end
      check("t6_no_frame", 32'(n), 32'd0);
      strobe(16'h0001);
      push_frame(16'h0001);
      wait_end("t6_end_timeout");

      repeat (5) @(negedge clk);
      check("sb_empty", 32'(sb.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
